// File: rtl/reg_bus_arbiter_if.sv
// Shared register-load bus: requester side drives req/dst/data, arbiter side
// answers with grant, bus value, one-hot load enable and status.
interface reg_bus_arbiter_if #(
  parameter int NREQ = 4,
  parameter int NREG = 6,
  parameter int DSTW = 3,
  parameter int DW   = 18
);
  logic [NREQ-1:0]      req;
  logic [NREQ*DSTW-1:0] dst;
  logic [NREQ*DW-1:0]   data;
  logic [NREQ-1:0]      gnt;
  logic [DW-1:0]        bus;
  logic [NREG-1:0]      ld_en;
  logic                 busy;
  logic                 err;

  // requesters
  modport master (output req, dst, data, input gnt, bus, ld_en, busy, err);
  // arbiter
  modport slave  (input req, dst, data, output gnt, bus, ld_en, busy, err);
endinterface

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter / load sequencer for the shared register-load bus.
// Posedge-clocked; bus and ld_en settle half a cycle before the negedge
// datapath registers capture. Every transfer is XFER for one cycle followed
// by a mandatory IDLE turnaround cycle.
module reg_bus_arbiter #(
  parameter int NREQ = 4,
  parameter int NREG = 6,
  parameter int DSTW = 3,
  parameter int DW   = 18
) (
  input  logic               clk,
  input  logic               rst,
  reg_bus_arbiter_if.slave   bif
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, XFER} state_t;

  state_t                    state;
  logic [PW-1:0]             ptr;     // last winner; search starts one above
  logic [PW-1:0]             cur;     // winner of the transfer in flight
  logic [PW-1:0]             win;
  logic                      win_vld;
  int unsigned               idx;

  logic [NREQ-1:0][DSTW-1:0] dst_a;
  logic [NREQ-1:0][DW-1:0]   data_a;

  // per-requester fields are packed back to back, lowest requester at lsb
  assign dst_a  = bif.dst;
  assign data_a = bif.data;

  // pick the first requester with req high, starting at ptr+1 and wrapping
  always_comb begin
    win     = ptr;
    win_vld = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!win_vld && bif.req[idx]) begin
        win     = PW'(idx);
        win_vld = 1'b1;
      end
    end
  end

  // transfer FSM with registered bus, grant, load enable and status
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= PW'(NREQ-1);
      cur       <= '0;
      bif.gnt   <= '0;
      bif.bus   <= '0;
      bif.ld_en <= '0;
      bif.busy  <= 1'b0;
      bif.err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            state    <= XFER;
            cur      <= win;
            bif.bus  <= data_a[win];
            bif.gnt  <= NREQ'(1) << win;
            bif.busy <= 1'b1;
            // out-of-range destination: acknowledge but load nothing
            if (int'(dst_a[win]) < NREG) bif.ld_en <= NREG'(1) << dst_a[win];
            else                         bif.err   <= 1'b1;
          end
        end
        XFER: begin
          // bus keeps its value; only the strobes drop
          state     <= IDLE;
          ptr       <= cur;
          bif.gnt   <= '0;
          bif.ld_en <= '0;
          bif.busy  <= 1'b0;
          bif.err   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter: reset, single load, round-robin order,
// invalid destination, reset mid-transfer and request during XFER.
module tb_reg_bus_arbiter;
  localparam int NREQ = 4;
  localparam int NREG = 6;
  localparam int DSTW = 3;
  localparam int DW   = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   ntest = 0;
  int   nfail = 0;

  reg_bus_arbiter_if #(.NREQ(NREQ), .NREG(NREG), .DSTW(DSTW), .DW(DW)) bif();

  reg_bus_arbiter #(.NREQ(NREQ), .NREG(NREG), .DSTW(DSTW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    ntest++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [DSTW-1:0] d, input logic [DW-1:0] v);
    bif.dst[i*DSTW +: DSTW] = d;
    bif.data[i*DW +: DW]    = v;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".gnt"},   32'(bif.gnt),   32'h0);
    chk({tag, ".ld_en"}, 32'(bif.ld_en), 32'h0);
    chk({tag, ".busy"},  32'(bif.busy),  32'h0);
    chk({tag, ".err"},   32'(bif.err),   32'h0);
  endtask

  logic [NREQ-1:0] pend;
  int              w;

  initial begin
    bif.req  = '0;
    bif.dst  = '0;
    bif.data = '0;
    for (int i = 0; i < NREQ; i++) set_src(i, DSTW'(i), DW'(18'h01000 + i));

    // reset held 3 cycles with every requester asking
    rst     = 1'b1;
    bif.req = 4'b1111;
    for (int c = 0; c < 3; c++) tick();
    chk_idle("rst");
    chk("rst.bus", 32'(bif.bus), 32'h0);
    rst = 1'b0;
    tick();
    chk("rst_first.gnt",   32'(bif.gnt),   32'h1);
    chk("rst_first.ld_en", 32'(bif.ld_en), 32'h01);
    chk("rst_first.bus",   32'(bif.bus),   32'h01000);
    bif.req = '0;
    tick();
    chk_idle("rst_first_end");

    // single transfer from requester 2 to register 3
    set_src(2, 3'd3, 18'h2A5C5);
    bif.req = 4'b0100;
    tick();
    chk("single.gnt",   32'(bif.gnt),   32'h4);
    chk("single.ld_en", 32'(bif.ld_en), 32'h08);
    chk("single.bus",   32'(bif.bus),   32'h2A5C5);
    chk("single.busy",  32'(bif.busy),  32'h1);
    chk("single.err",   32'(bif.err),   32'h0);
    bif.req = '0;
    tick();
    chk_idle("single_end");
    chk("single_end.bus", 32'(bif.bus), 32'h2A5C5);
    tick();
    chk("single_hold.bus", 32'(bif.bus), 32'h2A5C5);
    chk("single_hold.gnt", 32'(bif.gnt), 32'h0);

    // round robin: fresh reset so requester 0 leads, all four requesting
    set_src(2, 3'd2, 18'h01002);
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    bif.req = 4'b1111;
    pend    = '0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e % 2 == 1) begin
        w = ((e - 1) / 2) % NREQ;
        chk($sformatf("rr%0d.gnt", e),   32'(bif.gnt),   32'(1) << w);
        chk($sformatf("rr%0d.ld_en", e), 32'(bif.ld_en), 32'(1) << w);
        chk($sformatf("rr%0d.bus", e),   32'(bif.bus),   32'h01000 + 32'(w));
      end else begin
        chk($sformatf("rr%0d.gnt", e), 32'(bif.gnt), 32'h0);
      end
      // re-raise last cycle's winner, drop this cycle's winner
      bif.req = (bif.req | pend) & ~bif.gnt;
      pend    = bif.gnt;
    end
    bif.req = '0;
    tick();

    // invalid destination from requester 1, then a valid one
    set_src(1, 3'd7, 18'h3FFFF);
    bif.req = 4'b0010;
    tick();
    chk("bad.gnt",   32'(bif.gnt),   32'h2);
    chk("bad.err",   32'(bif.err),   32'h1);
    chk("bad.ld_en", 32'(bif.ld_en), 32'h0);
    chk("bad.busy",  32'(bif.busy),  32'h1);
    bif.req = '0;
    tick();
    chk_idle("bad_end");
    set_src(1, 3'd5, 18'h12345);
    bif.req = 4'b0010;
    tick();
    chk("good.gnt",   32'(bif.gnt),   32'h2);
    chk("good.ld_en", 32'(bif.ld_en), 32'h20);
    chk("good.err",   32'(bif.err),   32'h0);
    chk("good.bus",   32'(bif.bus),   32'h12345);
    bif.req = '0;
    tick();

    // reset right after a grant to requester 1: ptr must return to NREQ-1
    bif.req = 4'b0010;
    tick();
    chk("mid.gnt", 32'(bif.gnt), 32'h2);
    bif.req = '0;
    rst     = 1'b1;
    tick();
    chk_idle("mid_rst");
    chk("mid_rst.bus", 32'(bif.bus), 32'h0);
    rst     = 1'b0;
    bif.req = 4'b0110;
    tick();
    chk("mid_next.gnt", 32'(bif.gnt), 32'h2);
    chk("mid_next.bus", 32'(bif.bus), 32'h12345);
    bif.req = '0;
    tick();

    // req[3] raised during requester 0's XFER is taken at the next IDLE edge
    bif.req = 4'b0001;
    tick();
    chk("late.gnt0", 32'(bif.gnt), 32'h1);
    bif.req = 4'b1000;
    tick();
    chk("late.turn", 32'(bif.gnt), 32'h0);
    tick();
    chk("late.gnt3",  32'(bif.gnt),   32'h8);
    chk("late.ld_en", 32'(bif.ld_en), 32'h08);
    chk("late.bus",   32'(bif.bus),   32'h01003);
    bif.req = '0;
    tick();
    chk_idle("late_end");

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule
